// File: rtl/axi2mem_rd_channel_np_if.sv
// rtl/axi2mem_rd_channel_np_if.sv - AXI4 AR/R channel bundle for the axi2mem read front end
interface axi2mem_rd_channel_np_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 3,
   parameter int unsigned USER_WIDTH = 6
);
   logic                  ar_valid;
   logic                  ar_ready;
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic [7:0]            ar_len;
   logic [2:0]            ar_size;
   logic [1:0]            ar_burst;
   logic [ID_WIDTH-1:0]   ar_id;

   logic                  r_valid;
   logic                  r_ready;
   logic [DATA_WIDTH-1:0] r_data;
   logic [1:0]            r_resp;
   logic                  r_last;
   logic [ID_WIDTH-1:0]   r_id;
   logic [USER_WIDTH-1:0] r_user;

   modport slave (
      input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, r_ready,
      output ar_ready, r_valid, r_data, r_resp, r_last, r_id, r_user
   );

   modport master (
      output ar_valid, ar_addr, ar_len, ar_size, ar_burst, ar_id, r_ready,
      input  ar_ready, r_valid, r_data, r_resp, r_last, r_id, r_user
   );
endinterface

// File: rtl/axi2mem_rd_channel_np.sv
// rtl/axi2mem_rd_channel_np.sv - AXI4 read burst splitter onto NB_PORTS TCDM ports with in-order R return
module axi2mem_rd_channel_np #(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter int unsigned AXI_ID_WIDTH   = 3,
   parameter int unsigned AXI_USER_WIDTH = 6,
   parameter int unsigned NB_PORTS       = 2,
   parameter int unsigned ID_FIFO_DEPTH  = 4
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   test_en_i,
   axi2mem_rd_channel_np_if.slave                 axi,
   output logic [NB_PORTS-1:0]                    trans_req_o,
   output logic [NB_PORTS-1:0][31:0]              trans_add_o,
   output logic [NB_PORTS-1:0][3:0]               trans_be_o,
   output logic [NB_PORTS-1:0]                    trans_last_o,
   output logic [NB_PORTS-1:0][AXI_ID_WIDTH-1:0]  trans_id_o,
   input  logic [NB_PORTS-1:0]                    trans_gnt_i,
   input  logic [AXI_DATA_WIDTH-1:0]              data_dat_i,
   input  logic                                   data_valid_i,
   input  logic                                   data_last_i,
   output logic                                   data_req_o
);
   localparam int MAX_SIZE = $clog2(AXI_DATA_WIDTH / 8);
   localparam int BYTES    = AXI_DATA_WIDTH / 8;
   localparam int BW       = MAX_SIZE + 1;
   localparam int AW       = AXI_ADDR_WIDTH;
   localparam int PTR_W    = $clog2(ID_FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_e;

   state_e                  state_q, state_d;
   logic [AW-1:0]           addr_q, addr_d;
   logic [7:0]              len_q, len_d, cnt_q, cnt_d, err_cnt_q, err_cnt_d;
   logic [2:0]              size_q, size_d;
   logic [1:0]              burst_q, burst_d;
   logic [AXI_ID_WIDTH-1:0] id_q, id_d;

   logic [AXI_ID_WIDTH-1:0] fifo_mem [ID_FIFO_DEPTH];
   logic [PTR_W-1:0]        wptr_q, rptr_q;
   logic [PTR_W:0]          count_q;
   logic                    fifo_full, fifo_empty, push, pop;

   logic                    all_gnt, ar_illegal, ar_ready_s, issue, last;
   logic [AW-1:0]           size_mask_ar, start_ar, beat_addr, word_base;
   logic [2:0]              cur_size;
   logic [AXI_ID_WIDTH-1:0] cur_id;
   logic [BW-1:0]           lo, hi;
   logic [BYTES-1:0]        byte_mask;
   logic [AXI_DATA_WIDTH-1:0] err_data, r_data_s;
   logic                    r_valid_s, r_last_s, data_req_s;
   logic [1:0]              r_resp_s;
   logic                    unused_test_en;

   assign unused_test_en = test_en_i;

   // Beat i of a burst; WRAP keeps the upper bits and wraps the offset inside the wrap window.
   function automatic logic [AW-1:0] beat_addr_f(input logic [AW-1:0] start, input logic [7:0] len,
                                                 input logic [2:0] size, input logic [1:0] burst,
                                                 input logic [7:0] idx);
      logic [AW-1:0] incr, bound_m1;
      incr     = start + (AW'(idx) << size);
      bound_m1 = ((AW'(len) + AW'(1)) << size) - AW'(1);
      case (burst)
         2'b00:   return start;
         2'b10:   return (start & ~bound_m1) | (incr & bound_m1);
         default: return incr;
      endcase
   endfunction

   assign all_gnt      = &trans_gnt_i;
   assign fifo_full    = (count_q == (PTR_W+1)'(ID_FIFO_DEPTH));
   assign fifo_empty   = (count_q == '0);
   assign size_mask_ar = (AW'(1) << axi.ar_size) - AW'(1);
   assign start_ar     = axi.ar_addr & ~size_mask_ar;
   assign ar_illegal   = (axi.ar_burst == 2'b11) || (int'(axi.ar_size) > MAX_SIZE) ||
                         ((axi.ar_burst == 2'b10) &&
                          (!(axi.ar_len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                           ((axi.ar_addr & size_mask_ar) != '0)));

   always_comb begin
      beat_addr = start_ar;
      cur_size  = axi.ar_size;
      cur_id    = axi.ar_id;
      if (state_q == RUN) begin
         beat_addr = beat_addr_f(addr_q, len_q, size_q, burst_q, cnt_q + 8'd1);
         cur_size  = size_q;
         cur_id    = id_q;
      end
   end

   assign word_base = {beat_addr[AW-1:MAX_SIZE], {MAX_SIZE{1'b0}}};
   assign lo        = {1'b0, beat_addr[MAX_SIZE-1:0]};
   assign hi        = lo + (BW'(1) << cur_size);

   always_comb begin
      byte_mask = '0;
      for (int j = 0; j < BYTES; j++) begin
         byte_mask[j] = (BW'(j) >= lo) && (BW'(j) < hi);
      end
   end

   for (genvar k = 0; k < NB_PORTS; k++) begin : g_port
      assign trans_req_o[k]  = issue;
      assign trans_last_o[k] = last;
      assign trans_id_o[k]   = cur_id;
      assign trans_add_o[k]  = 32'(word_base) + 32'(4 * k);
      assign trans_be_o[k]   = byte_mask[4*k +: 4];
      assign err_data[32*k +: 32] = (k % 2 == 0) ? 32'hDEAD_BEEF : 32'hCA11_AB1E;
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      size_d     = size_q;
      burst_d    = burst_q;
      id_d       = id_q;
      cnt_d      = cnt_q;
      err_cnt_d  = err_cnt_q;
      ar_ready_s = 1'b0;
      issue      = 1'b0;
      last       = 1'b0;
      push       = 1'b0;
      r_valid_s  = data_valid_i;
      r_data_s   = data_dat_i;
      r_last_s   = data_last_i;
      r_resp_s   = 2'b00;
      data_req_s = data_valid_i & axi.r_ready;
      case (state_q)
         IDLE: begin
            ar_ready_s = !fifo_full && ((!ar_illegal && all_gnt) || (ar_illegal && fifo_empty));
            if (axi.ar_valid) begin
               if (!ar_illegal) begin
                  if (ar_ready_s) begin
                     issue = 1'b1;
                     push  = 1'b1;
                     if (axi.ar_len == 8'd0) begin
                        last = 1'b1;
                     end else begin
                        addr_d  = start_ar;
                        len_d   = axi.ar_len;
                        size_d  = axi.ar_size;
                        burst_d = axi.ar_burst;
                        id_d    = axi.ar_id;
                        cnt_d   = 8'd0;
                        state_d = RUN;
                     end
                  end
               end else if (!fifo_empty) begin
                  state_d = DRAIN;
               end else if (ar_ready_s) begin
                  push      = 1'b1;
                  err_cnt_d = axi.ar_len;
                  state_d   = ERR;
               end
            end
         end
         RUN: begin
            if (all_gnt) begin
               issue = 1'b1;
               cnt_d = cnt_q + 8'd1;
               if ((cnt_q + 8'd1) == len_q) begin
                  last    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         DRAIN: begin
            if (fifo_empty) state_d = IDLE;
         end
         ERR: begin
            r_valid_s  = 1'b1;
            r_data_s   = err_data;
            r_last_s   = (err_cnt_q == 8'd0);
            r_resp_s   = 2'b10;
            data_req_s = 1'b0;
            if (axi.r_ready) begin
               if (err_cnt_q == 8'd0) state_d = IDLE;
               else                   err_cnt_d = err_cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pop           = r_valid_s && axi.r_ready && r_last_s && !fifo_empty;
   assign axi.ar_ready  = ar_ready_s;
   assign axi.r_valid   = r_valid_s;
   assign axi.r_data    = r_data_s;
   assign axi.r_last    = r_last_s;
   assign axi.r_resp    = r_resp_s;
   assign axi.r_id      = fifo_mem[rptr_q];
   assign axi.r_user    = '0;
   assign data_req_o    = data_req_s;

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wptr_q] <= axi.ar_id;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         id_q      <= '0;
         cnt_q     <= '0;
         err_cnt_q <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         id_q      <= id_d;
         cnt_q     <= cnt_d;
         err_cnt_q <= err_cnt_d;
         if (push) wptr_q <= wptr_q + PTR_W'(1);
         if (pop)  rptr_q <= rptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: tb/tb_axi2mem_rd_channel_np.sv
// tb/tb_axi2mem_rd_channel_np.sv - directed self-checking bench for axi2mem_rd_channel_np
module tb_axi2mem_rd_channel_np;
   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             test_en_i;
   logic [1:0]       trans_req;
   logic [1:0][31:0] trans_add;
   logic [1:0][3:0]  trans_be;
   logic [1:0]       trans_last;
   logic [1:0][2:0]  trans_id;
   logic [1:0]       trans_gnt;
   logic [63:0]      data_dat;
   logic             data_valid, data_last, data_req;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   axi2mem_rd_channel_np_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(3), .USER_WIDTH(6)) axi_if ();

   axi2mem_rd_channel_np #(
      .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(3),
      .AXI_USER_WIDTH(6), .NB_PORTS(2), .ID_FIFO_DEPTH(4)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .test_en_i    (test_en_i),
      .axi          (axi_if),
      .trans_req_o  (trans_req),
      .trans_add_o  (trans_add),
      .trans_be_o   (trans_be),
      .trans_last_o (trans_last),
      .trans_id_o   (trans_id),
      .trans_gnt_i  (trans_gnt),
      .data_dat_i   (data_dat),
      .data_valid_i (data_valid),
      .data_last_i  (data_last),
      .data_req_o   (data_req)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk_i);
   endtask

   task automatic set_ar(input logic v, input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b, input logic [2:0] id);
      axi_if.ar_valid = v;
      axi_if.ar_addr  = a;
      axi_if.ar_len   = l;
      axi_if.ar_size  = s;
      axi_if.ar_burst = b;
      axi_if.ar_id    = id;
   endtask

   task automatic chk_beat(input string tag, input logic [63:0] add, input logic [7:0] be,
                           input logic [1:0] lst);
      check_val({tag, "_req"}, 64'(trans_req), 64'h3);
      check_val({tag, "_add"}, 64'(trans_add), add);
      check_val({tag, "_be"}, 64'(trans_be), 64'(be));
      check_val({tag, "_last"}, 64'(trans_last), 64'(lst));
   endtask

   task automatic drain_one(input string tag, input logic [2:0] id, input logic [63:0] d);
      data_dat = d; data_valid = 1'b1; data_last = 1'b1; axi_if.r_ready = 1'b1;
      #1;
      check_val({tag, "_rvalid"}, 64'(axi_if.r_valid), 64'h1);
      check_val({tag, "_rid"}, 64'(axi_if.r_id), 64'(id));
      check_val({tag, "_rdata"}, axi_if.r_data, d);
      check_val({tag, "_rlast"}, 64'(axi_if.r_last), 64'h1);
      check_val({tag, "_rresp"}, 64'(axi_if.r_resp), 64'h0);
      check_val({tag, "_dreq"}, 64'(data_req), 64'h1);
      nxt();
      data_valid = 1'b0; data_last = 1'b0; axi_if.r_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic found;
      int   waited;
      rst_ni = 1'b0; test_en_i = 1'b0; trans_gnt = 2'b11;
      data_dat = '0; data_valid = 1'b0; data_last = 1'b0; axi_if.r_ready = 1'b0;
      set_ar(1'b0, 32'h0, 8'd0, 3'd0, 2'b01, 3'd0);
      nxt(); #1;
      check_val("rst_ar_ready", 64'(axi_if.ar_ready), 64'h1);
      check_val("rst_treq", 64'(trans_req), 64'h0);
      check_val("rst_rvalid", 64'(axi_if.r_valid), 64'h0);
      check_val("rst_dreq", 64'(data_req), 64'h0);
      nxt(); rst_ni = 1'b1;
      nxt();

      // INCR len=3 size=3 @0x1000
      set_ar(1'b1, 32'h1000, 8'd3, 3'd3, 2'b01, 3'd5); #1;
      check_val("incr_ar_ready", 64'(axi_if.ar_ready), 64'h1);
      check_val("incr_tid", 64'(trans_id), 64'h2D);
      chk_beat("incr_b0", 64'h00001004_00001000, 8'hFF, 2'b00);
      nxt(); axi_if.ar_valid = 1'b0; #1;
      check_val("incr_run_ar_ready", 64'(axi_if.ar_ready), 64'h0);
      chk_beat("incr_b1", 64'h0000100C_00001008, 8'hFF, 2'b00);
      nxt(); #1; chk_beat("incr_b2", 64'h00001014_00001010, 8'hFF, 2'b00);
      nxt(); #1; chk_beat("incr_b3", 64'h0000101C_00001018, 8'hFF, 2'b11);
      nxt(); #1;
      check_val("incr_next_ar", 64'(axi_if.ar_ready), 64'h1);
      drain_one("incr_r", 3'd5, 64'h1111_2222_3333_4444);

      // WRAP len=3 size=2 @0x2008
      set_ar(1'b1, 32'h2008, 8'd3, 3'd2, 2'b10, 3'd2); #1;
      chk_beat("wrap_b0", 64'h0000200C_00002008, 8'h0F, 2'b00);
      nxt(); axi_if.ar_valid = 1'b0; #1;
      chk_beat("wrap_b1", 64'h0000200C_00002008, 8'hF0, 2'b00);
      nxt(); #1; chk_beat("wrap_b2", 64'h00002004_00002000, 8'h0F, 2'b00);
      nxt(); #1; chk_beat("wrap_b3", 64'h00002004_00002000, 8'hF0, 2'b11);
      nxt();
      drain_one("wrap_r", 3'd2, 64'h5555_6666_7777_8888);

      // FIXED len=2 size=0 @0x3003
      set_ar(1'b1, 32'h3003, 8'd2, 3'd0, 2'b00, 3'd3); #1;
      chk_beat("fix_b0", 64'h00003004_00003000, 8'h08, 2'b00);
      nxt(); axi_if.ar_valid = 1'b0; #1;
      chk_beat("fix_b1", 64'h00003004_00003000, 8'h08, 2'b00);
      nxt(); #1; chk_beat("fix_b2", 64'h00003004_00003000, 8'h08, 2'b11);
      nxt();
      drain_one("fix_r", 3'd3, 64'h9999_AAAA_BBBB_CCCC);

      // four outstanding single-beat reads fill the ID FIFO
      for (int i = 1; i <= 4; i++) begin
         set_ar(1'b1, 32'h4000, 8'd0, 3'd3, 2'b01, 3'(i)); #1;
         check_val($sformatf("out%0d_ar_ready", i), 64'(axi_if.ar_ready), 64'h1);
         check_val($sformatf("out%0d_last", i), 64'(trans_last), 64'h3);
         nxt();
      end
      set_ar(1'b1, 32'h4000, 8'd0, 3'd3, 2'b01, 3'd5); #1;
      check_val("full_ar_ready", 64'(axi_if.ar_ready), 64'h0);
      check_val("full_treq", 64'(trans_req), 64'h0);
      nxt(); axi_if.ar_valid = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         data_dat = 64'hA0 + 64'(i); data_valid = 1'b1; data_last = 1'b1; axi_if.r_ready = 1'b0; #1;
         check_val($sformatf("ord%0d_hold_valid", i), 64'(axi_if.r_valid), 64'h1);
         check_val($sformatf("ord%0d_hold_id", i), 64'(axi_if.r_id), 64'(i));
         check_val($sformatf("ord%0d_hold_dreq", i), 64'(data_req), 64'h0);
         nxt(); axi_if.r_ready = 1'b1; #1;
         check_val($sformatf("ord%0d_id", i), 64'(axi_if.r_id), 64'(i));
         check_val($sformatf("ord%0d_data", i), axi_if.r_data, 64'hA0 + 64'(i));
         check_val($sformatf("ord%0d_dreq", i), 64'(data_req), 64'h1);
         nxt();
      end
      data_valid = 1'b0; data_last = 1'b0; axi_if.r_ready = 1'b0;

      // illegal burst behind one outstanding read: DRAIN, then error response
      set_ar(1'b1, 32'h6000, 8'd0, 3'd3, 2'b01, 3'd6); #1;
      check_val("err_pre_ar_ready", 64'(axi_if.ar_ready), 64'h1);
      nxt();
      set_ar(1'b1, 32'h6000, 8'd2, 3'd3, 2'b11, 3'd7); #1;
      check_val("err_idle_block", 64'(axi_if.ar_ready), 64'h0);
      nxt(); #1;
      check_val("err_drain_block", 64'(axi_if.ar_ready), 64'h0);
      drain_one("err_prev_r", 3'd6, 64'h0BAD_F00D_0000_0001);
      found = 1'b0; waited = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         #1;
         if (axi_if.ar_ready) found = 1'b1;
         else begin waited++; nxt(); end
      end
      check_val("err_accept", 64'(found), 64'h1);
      check_val("err_accept_wait", 64'(waited), 64'h1);
      nxt(); axi_if.ar_valid = 1'b0;
      data_valid = 1'b1; data_dat = 64'h1234; data_last = 1'b0; axi_if.r_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         #1;
         check_val($sformatf("err%0d_valid", b), 64'(axi_if.r_valid), 64'h1);
         check_val($sformatf("err%0d_resp", b), 64'(axi_if.r_resp), 64'h2);
         check_val($sformatf("err%0d_data", b), axi_if.r_data, 64'hCA11_AB1E_DEAD_BEEF);
         check_val($sformatf("err%0d_last", b), 64'(axi_if.r_last), (b == 2) ? 64'h1 : 64'h0);
         check_val($sformatf("err%0d_id", b), 64'(axi_if.r_id), 64'h7);
         check_val($sformatf("err%0d_dreq", b), 64'(data_req), 64'h0);
         nxt();
      end
      data_valid = 1'b0;
      set_ar(1'b0, 32'h6000, 8'd0, 3'd3, 2'b01, 3'd0); #1;
      check_val("err_done_rvalid", 64'(axi_if.r_valid), 64'h0);
      check_val("err_done_ar_ready", 64'(axi_if.ar_ready), 64'h1);
      nxt(); axi_if.r_ready = 1'b0;

      // grant stalls mid-burst, then reset mid-burst
      trans_gnt = 2'b10; #1;
      check_val("gnt_idle_ar_ready", 64'(axi_if.ar_ready), 64'h0);
      nxt(); trans_gnt = 2'b11;
      set_ar(1'b1, 32'h5000, 8'd7, 3'd3, 2'b01, 3'd1); #1;
      chk_beat("stall_b0", 64'h00005004_00005000, 8'hFF, 2'b00);
      nxt(); axi_if.ar_valid = 1'b0; #1;
      chk_beat("stall_b1", 64'h0000500C_00005008, 8'hFF, 2'b00);
      nxt(); trans_gnt = 2'b10;
      for (int c = 0; c < 3; c++) begin
         #1; check_val($sformatf("stall%0d_treq", c), 64'(trans_req), 64'h0);
         nxt();
      end
      trans_gnt = 2'b11; #1;
      chk_beat("stall_b2", 64'h00005014_00005010, 8'hFF, 2'b00);
      nxt(); rst_ni = 1'b0; #1;
      check_val("midrst_treq", 64'(trans_req), 64'h0);
      nxt(); rst_ni = 1'b1;
      set_ar(1'b0, 32'h7000, 8'd0, 3'd0, 2'b11, 3'd0); #1;
      check_val("midrst_fifo_empty", 64'(axi_if.ar_ready), 64'h1);
      check_val("midrst_treq_after", 64'(trans_req), 64'h0);
      nxt();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
